// File: rtl/lut_neuron_pipe.sv
// ----------------------------------------------------------------------------
// lut_neuron_pipe
// Lookup-table neuron. A register-array table of 2**IN_W entries, each OUT_W
// bits wide, is read through a two-stage valid/ready pipeline: S1 registers
// the lookup address, and S2 registers the table entry and drives the output.
// The table is initialised to INIT_VAL by a sweep after reset, and again on
// request. It can be rewritten one entry per cycle through the cfg port while
// the block is running.
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   lookup request valid
//   in_ready   lookup accepted this cycle
//   in_data    lookup address [IN_W]
//   out_valid  result valid
//   out_ready  downstream accepts result
//   out_data   table entry for the accepted address [OUT_W]
//   cfg_we     table write strobe
//   cfg_addr   table write address [IN_W]
//   cfg_data   table write data [OUT_W]
//   cfg_ready  cfg_we is honoured this cycle
//   clr_req    single-cycle request to reinitialise the table
//   busy       high while draining or clearing
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// ST_CLEAR | sweep ptr over the table writing INIT_VAL, one entry per cycle
// ST_RUN   | accept lookups and cfg writes
// ST_DRAIN | no new lookups; wait for S1 and S2 to empty, then clear
// ----------------------------------------------------------------------------
module lut_neuron_pipe #(
   parameter int               IN_W     = 8,
   parameter int               OUT_W    = 2,
   parameter logic [OUT_W-1:0] INIT_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   input  logic             cfg_we,
   input  logic [IN_W-1:0]  cfg_addr,
   input  logic [OUT_W-1:0] cfg_data,
   output logic             cfg_ready,
   input  logic             clr_req,
   output logic             busy
);

   localparam int DEPTH = 2**IN_W;

   typedef enum logic [1:0] {
      ST_CLEAR,
      ST_RUN,
      ST_DRAIN
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [IN_W-1:0]  ptr_q;

   logic [OUT_W-1:0] lut_mem [DEPTH];

   logic             s1_valid_q;
   logic [IN_W-1:0]  s1_addr_q;
   logic             s2_valid_q;
   logic [OUT_W-1:0] s2_data_q;

   logic             s2_open;
   logic             s1_open;
   logic             in_fire;
   logic             clear_last;
   logic [OUT_W-1:0] lut_rd;

   // A stage can load when it is empty or its content leaves at this edge.
   assign s2_open    = !s2_valid_q || out_ready;
   assign s1_open    = !s1_valid_q || s2_open;

   assign in_ready   = (state_q == ST_RUN) && s1_open;
   assign in_fire    = in_valid && in_ready;
   assign cfg_ready  = (state_q == ST_RUN);
   assign busy       = (state_q != ST_RUN);
   assign out_valid  = s2_valid_q;
   assign out_data   = s2_data_q;
   assign clear_last = (ptr_q == '1);

   // Combinational read; a cfg write at the same edge lands after S2 samples,
   // so a colliding read returns the old entry.
   assign lut_rd     = lut_mem[s1_addr_q];

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_CLEAR: if (clear_last)                 state_d = ST_RUN;
         ST_RUN:   if (clr_req)                    state_d = ST_DRAIN;
         ST_DRAIN: if (!s1_valid_q && !s2_valid_q) state_d = ST_CLEAR;
         default:                                  state_d = ST_CLEAR;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_CLEAR;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         // ptr wraps to zero on the last clear write, and sits at zero
         // outside CLEAR so every sweep starts at entry 0.
         if (state_q == ST_CLEAR) ptr_q <= ptr_q + IN_W'(1);
         else                     ptr_q <= '0;
      end
   end

   // Table contents are deliberately not reset; the CLEAR sweep defines them.
   always_ff @(posedge clk) begin
      if (state_q == ST_CLEAR)
         lut_mem[ptr_q] <= INIT_VAL;
      else if (cfg_we && cfg_ready)
         lut_mem[cfg_addr] <= cfg_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_addr_q  <= '0;
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
      end else begin
         if (s1_open) begin
            s1_valid_q <= in_fire;
            if (in_fire) s1_addr_q <= in_data;
         end
         if (s2_open) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) s2_data_q <= lut_rd;
         end
      end
   end

endmodule

// File: tb/tb_lut_neuron_pipe.sv
// ----------------------------------------------------------------------------
// tb_lut_neuron_pipe
// Directed bench for lut_neuron_pipe (IN_W=8, OUT_W=2, INIT_VAL=2'b10).
// Inputs are driven 1 ns after the rising edge; outputs are sampled there too.
// ----------------------------------------------------------------------------
module tb_lut_neuron_pipe;

   localparam int         IN_W  = 8;
   localparam int         OUT_W = 2;
   localparam logic [1:0] INIT  = 2'b10;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in_data;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_data;
   logic             cfg_we;
   logic [IN_W-1:0]  cfg_addr;
   logic [OUT_W-1:0] cfg_data;
   logic             cfg_ready;
   logic             clr_req;
   logic             busy;

   lut_neuron_pipe #(
      .IN_W    (IN_W),
      .OUT_W   (OUT_W),
      .INIT_VAL(INIT)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .cfg_we   (cfg_we),
      .cfg_addr (cfg_addr),
      .cfg_data (cfg_data),
      .cfg_ready(cfg_ready),
      .clr_req  (clr_req),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   logic [IN_W-1:0]  s_addr [256];
   logic [OUT_W-1:0] s_exp  [256];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic count_busy(output int n);
      n = 0;
      while (busy && n < 1000) begin
         tick();
         n++;
      end
   endtask

   task automatic wait_in_ready(input string tag);
      int k = 0;
      #1;
      while (!in_ready && k < 50) begin
         tick();
         k++;
      end
      check({tag, " in_ready timeout"}, 32'(k < 50), 32'd1);
   endtask

   task automatic cfg_write(input logic [7:0] a, input logic [1:0] d);
      cfg_we   = 1'b1;
      cfg_addr = a;
      cfg_data = d;
      #1;
      check("cfg_ready in RUN", 32'(cfg_ready), 32'd1);
      tick();
      cfg_we = 1'b0;
   endtask

   // Single lookup on an idle pipeline with out_ready=1; result must appear
   // exactly two edges after it is presented, and not one.
   task automatic lookup(input logic [7:0] a, input logic [1:0] exp, input string tag);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = a;
      wait_in_ready(tag);
      tick();
      in_valid = 1'b0;
      check({tag, " early valid"}, 32'(out_valid), 32'd0);
      tick();
      check({tag, " out_valid"}, 32'(out_valid), 32'd1);
      check({tag, " out_data"}, 32'(out_data), 32'(exp));
      tick();
   endtask

   task automatic stream(input int n, input bit toggle, input string tag);
      int         sent    = 0;
      int         recv    = 0;
      int         cyc     = 0;
      bit         stalled = 1'b0;
      logic [1:0] hold_d  = '0;
      while (recv < n && cyc < 2000) begin
         in_valid  = (sent < n);
         in_data   = (sent < n) ? s_addr[sent] : '0;
         out_ready = toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
         #1;
         if (stalled)
            check({tag, " stall hold"}, 32'({out_valid, out_data}), 32'({1'b1, hold_d}));
         if (out_valid && out_ready) begin
            check(tag, 32'(out_data), 32'(s_exp[recv]));
            recv++;
         end
         stalled = out_valid && !out_ready;
         hold_d  = out_data;
         if (in_valid && in_ready) sent++;
         tick();
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check({tag, " count"}, 32'(recv), 32'(n));
   endtask

   int n;

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      cfg_we    = 1'b0;
      cfg_addr  = '0;
      cfg_data  = '0;
      clr_req   = 1'b0;

      // Reset values before any clock edge
      #2;
      check("rst busy", 32'(busy), 32'd1);
      check("rst in_ready", 32'(in_ready), 32'd0);
      check("rst cfg_ready", 32'(cfg_ready), 32'd0);
      check("rst out_valid", 32'(out_valid), 32'd0);
      check("rst out_data", 32'(out_data), 32'd0);

      tick();
      tick();
      rst_n = 1'b1;
      count_busy(n);
      check("initial clear length", 32'(n), 32'd256);
      check("run in_ready", 32'(in_ready), 32'd1);
      check("run cfg_ready", 32'(cfg_ready), 32'd1);

      lookup(8'h00, INIT, "init 00");
      lookup(8'h55, INIT, "init 55");
      lookup(8'hFF, INIT, "init ff");

      cfg_write(8'h6A, 2'b11);
      lookup(8'h6A, 2'b11, "write 6a");

      // Read/write collision: S1 holds 0x10 while a write to 0x10 lands
      cfg_write(8'h10, 2'b10);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 8'h10;
      wait_in_ready("collide");
      tick();
      in_valid = 1'b0;
      cfg_we   = 1'b1;
      cfg_addr = 8'h10;
      cfg_data = 2'b01;
      tick();
      cfg_we = 1'b0;
      check("collide valid", 32'(out_valid), 32'd1);
      check("collide old data", 32'(out_data), 32'd2);
      tick();
      lookup(8'h10, 2'b01, "collide new");

      // Back-to-back stream with out_ready 1,0,0,1,...
      for (int i = 0; i < 8; i++) begin
         s_addr[i] = 8'(8'h20 + i);
         s_exp[i]  = 2'((i * 3 + 1) % 4);
         cfg_write(s_addr[i], s_exp[i]);
      end
      stream(8, 1'b1, "stream");

      // Two results stalled, then clr_req
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h6A;
      wait_in_ready("bp first");
      tick();
      in_data = 8'h10;
      wait_in_ready("bp second");
      tick();
      in_valid = 1'b0;
      tick();
      check("bp out_valid", 32'(out_valid), 32'd1);
      check("bp out_data", 32'(out_data), 32'd3);
      check("bp in_ready full", 32'(in_ready), 32'd0);
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      check("drain busy", 32'(busy), 32'd1);
      check("drain in_ready", 32'(in_ready), 32'd0);
      check("drain cfg_ready", 32'(cfg_ready), 32'd0);
      tick();
      tick();
      check("drain hold", 32'(out_data), 32'd3);
      out_ready = 1'b1;
      #1;
      check("drain pop1 valid", 32'(out_valid), 32'd1);
      check("drain pop1 data", 32'(out_data), 32'd3);
      tick();
      check("drain pop2 valid", 32'(out_valid), 32'd1);
      check("drain pop2 data", 32'(out_data), 32'd1);
      tick();
      check("drain empty", 32'(out_valid), 32'd0);
      count_busy(n);
      check("drain+clear length", 32'(n), 32'd257);

      for (int i = 0; i < 256; i++) begin
         s_addr[i] = 8'(i);
         s_exp[i]  = INIT;
      end
      stream(256, 1'b0, "post clear");

      // Reset during a backpressured stream
      cfg_write(8'h6A, 2'b11);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h6A;
      tick();
      tick();
      tick();
      in_valid = 1'b0;
      check("pre-rst out_valid", 32'(out_valid), 32'd1);
      check("pre-rst out_data", 32'(out_data), 32'd3);
      rst_n = 1'b0;
      #1;
      check("mid-stream rst out_valid", 32'(out_valid), 32'd0);
      check("mid-stream rst out_data", 32'(out_data), 32'd0);
      check("mid-stream rst in_ready", 32'(in_ready), 32'd0);
      check("mid-stream rst cfg_ready", 32'(cfg_ready), 32'd0);
      check("mid-stream rst busy", 32'(busy), 32'd1);
      out_ready = 1'b1;
      tick();
      tick();
      rst_n = 1'b1;
      count_busy(n);
      check("clear after stream rst", 32'(n), 32'd256);

      // Reset during CLEAR at ptr=100
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      repeat (100) tick();
      rst_n = 1'b0;
      #1;
      check("mid-clear rst busy", 32'(busy), 32'd1);
      check("mid-clear rst in_ready", 32'(in_ready), 32'd0);
      check("mid-clear rst out_valid", 32'(out_valid), 32'd0);
      tick();
      rst_n = 1'b1;
      count_busy(n);
      check("clear restarts at 0", 32'(n), 32'd256);
      lookup(8'h6A, INIT, "post rst 6a");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
